// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_sub_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one operand pair per valid/ready transaction.
// Handshake: a transfer occurs on a rising edge where valid && ready are both high.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] diff,
    output logic            bout,
    output logic            ovf,
    output logic [1:0]      dbg_state_o
);

    localparam int CNT_W = $clog2(SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

    state_e            state_q;
    logic [SIZE-1:0]   a_q;
    logic [SIZE-1:0]   b_q;
    logic [SIZE-1:0]   res_q;
    logic [SIZE-1:0]   res_d;
    logic              br_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SIZE-1:0]   diff_q;
    logic              bout_q;
    logic              ovf_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              cell_d;
    logic              cell_bout;

    full_sub_cell u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (br_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    // Result bits arrive LSB first, so they enter at the MSB and shift down.
    assign res_d = {cell_d, res_q[SIZE-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            br_q        <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        br_q       <= bin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    br_q  <= cell_bout;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        // br_q is the borrow into the MSB on this final bit.
                        diff_q      <= res_d;
                        bout_q      <= cell_bout;
                        ovf_q       <= br_q ^ cell_bout;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign diff        = diff_q;
    assign bout        = bout_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised stream checks for serial_subtractor with SIZE=8.
module tb_serial_subtractor;

    localparam int SIZE = 8;
    localparam int W    = SIZE + 2;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            bin;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] diff;
    logic            bout;
    logic            ovf;
    logic [1:0]      dbg_state;

    int n_vec  = 0;
    int n_miss = 0;
    logic [W-1:0] exp_q[$];

    serial_subtractor #(.SIZE(SIZE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .bin         (bin),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .diff        (diff),
        .bout        (bout),
        .ovf         (ovf),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: {ovf, bout, diff}
    function automatic logic [W-1:0] model(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                                           input logic c);
        logic [SIZE:0] u;
        int s;
        u = {1'b0, x} - {1'b0, y} - {{SIZE{1'b0}}, c};
        s = int'($signed(x)) - int'($signed(y)) - int'(c);
        return {(s < -(2 ** (SIZE - 1))) || (s > (2 ** (SIZE - 1)) - 1), u[SIZE], u[SIZE-1:0]};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_diff"}, diff, 0);
        check({tag, "_bout"}, bout, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // driver: one full transaction, called at a negedge, returns at a negedge
    task automatic run_op(input logic [SIZE-1:0] op_a, input logic [SIZE-1:0] op_b,
                          input logic op_bin, input int stall, input logic [W-1:0] exp);
        int k;
        bit ready_seen;
        logic [W-1:0] e;
        exp_q.push_back(exp);
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", in_ready, 1);
        a = op_a;
        b = op_b;
        bin = op_bin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = SIZE'($urandom);
        b = SIZE'($urandom);
        bin = 1'($urandom);
        k = 0;
        ready_seen = 1'b0;
        while (!out_valid && k < 40) begin
            if (in_ready) ready_seen = 1'b1;
            @(negedge clk);
            k++;
            in_valid = 1'($urandom_range(0, 1));
            a = SIZE'($urandom);
            b = SIZE'($urandom);
        end
        check("latency", k, SIZE);
        check("busy_in_ready", ready_seen, 0);
        e = exp_q.pop_front();
        check("diff", diff, e[SIZE-1:0]);
        check("bout", bout, e[SIZE]);
        check("ovf", ovf, e[SIZE+1]);
        check("done_state", dbg_state, 2);
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a = SIZE'($urandom);
            b = SIZE'($urandom);
            @(negedge clk);
        end
        check("hold_out_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
        check("hold_result", {ovf, bout, diff}, e);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("handoff_out_valid", out_valid, 0);
        check("handoff_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [SIZE-1:0] ra;
        logic [SIZE-1:0] rb;
        logic            rc;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h50, 8'h20, 1'b0, 0, 10'h030);
        run_op(8'h00, 8'h01, 1'b0, 0, 10'h1FF);
        run_op(8'h10, 8'h0F, 1'b1, 0, 10'h000);
        run_op(8'h80, 8'h01, 1'b0, 1, 10'h27F);
        run_op(8'h7F, 8'hFF, 1'b0, 0, 10'h380);

        // backpressure with new operands offered during the stall
        run_op(8'h05, 8'h09, 1'b1, 5, 10'h1FB);
        run_op(8'h33, 8'h11, 1'b0, 0, 10'h022);

        // reset after three processed bits
        a = 8'hAA;
        b = 8'h55;
        bin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_state", dbg_state, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'hAA, 8'h55, 1'b0, 0, 10'h255);

        for (int n = 0; n < 200; n++) begin
            ra = SIZE'($urandom);
            rb = SIZE'($urandom);
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, $urandom_range(0, 3), model(ra, rb, rc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
